// File: rtl/counter_job_arbiter_if.sv
// Requester and counter-side signals of the shared mode-counter arbiter.
// master = arbiter side, slave = requesters plus counter.
interface counter_job_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] req_modo;
    logic [4*NREQ-1:0] req_d;
    logic [3:0]        Q;
    logic              RCO;
    logic              ENABLE;
    logic [1:0]        MODO;
    logic [3:0]        D;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              timeout;
    logic [3:0]        result_q;
    logic              busy;

    modport master (
        input  req, req_modo, req_d, Q, RCO,
        output ENABLE, MODO, D, gnt, done, timeout, result_q, busy
    );

    modport slave (
        output req, req_modo, req_d, Q, RCO,
        input  ENABLE, MODO, D, gnt, done, timeout, result_q, busy
    );
endinterface

// File: rtl/counter_job_arbiter.sv
// Round-robin arbiter that sequences LOAD/RUN/DONE jobs onto one
// shared 4-bit mode counter; sole driver of the counter controls.
module counter_job_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_CYCLES = 32,
    parameter int CW         = 6
) (
    input logic            clk,
    input logic            RESET,
    counter_job_arbiter_if.master bus
);
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [1:0]      mode_l;
    logic [3:0]      d_l;
    logic [CW-1:0]   cyc;

    logic            en_r;
    logic [1:0]      modo_r;
    logic [3:0]      d_r;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] done_r;
    logic            to_r;
    logic [3:0]      rq_r;
    logic            busy_r;

    logic [2*NREQ-1:0] rr;
    logic              found;
    logic [IW-1:0]     off;
    logic [IW:0]       sum;
    logic [IW-1:0]     pick;
    logic [1:0]        pmode;
    logic [3:0]        pd;
    logic [IW-1:0]     ptr_nxt;
    logic              budget_hit;

    // Rotate requests so bit 0 is the requester at ptr, then take first set bit.
    assign rr = {bus.req, bus.req} >> ptr;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rr[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
        end
        pick = sum[IW-1:0];
    end

    always_comb begin
        pmode = 2'b00;
        pd    = 4'h0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick == IW'(k)) begin
                pmode = bus.req_modo[2*k +: 2];
                pd    = bus.req_d[4*k +: 4];
            end
        end
    end

    assign ptr_nxt    = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
    assign budget_hit = (cyc == CW'(MAX_CYCLES-1));

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            ptr    <= '0;
            win    <= '0;
            mode_l <= 2'b00;
            d_l    <= 4'h0;
            cyc    <= '0;
            en_r   <= 1'b0;
            modo_r <= 2'b00;
            d_r    <= 4'h0;
            gnt_r  <= '0;
            done_r <= '0;
            to_r   <= 1'b0;
            rq_r   <= 4'h0;
            busy_r <= 1'b0;
        end else begin
            done_r <= '0;
            unique case (state)
                S_IDLE: begin
                    en_r <= 1'b0;
                    if (found) begin
                        win    <= pick;
                        gnt_r  <= NREQ'(1) << pick;
                        mode_l <= pmode;
                        d_l    <= pd;
                        busy_r <= 1'b1;
                        en_r   <= 1'b1;
                        modo_r <= 2'b11;
                        d_r    <= pd;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (mode_l == 2'b11) begin
                        en_r   <= 1'b0;
                        to_r   <= 1'b0;
                        rq_r   <= d_l;
                        done_r <= gnt_r;
                        state  <= S_DONE;
                    end else begin
                        cyc    <= '0;
                        modo_r <= mode_l;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    cyc <= cyc + 1'b1;
                    // RCO outranks the budget when both land on the same edge.
                    if (bus.RCO || budget_hit) begin
                        en_r   <= 1'b0;
                        to_r   <= ~bus.RCO;
                        rq_r   <= bus.Q;
                        done_r <= gnt_r;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    gnt_r  <= '0;
                    busy_r <= 1'b0;
                    ptr    <= ptr_nxt;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ENABLE   = en_r;
    assign bus.MODO     = modo_r;
    assign bus.D        = d_r;
    assign bus.gnt      = gnt_r;
    assign bus.done     = done_r;
    assign bus.timeout  = to_r;
    assign bus.result_q = rq_r;
    assign bus.busy     = busy_r;
endmodule
